// File: rtl/keypad_scan_if.sv
// keypad_scan_if -- bundles the keypad scanner's scan/keypad/key-event signals.
//   scan_tick : one-clk step strobe (master -> slave)
//   row_in    : keypad rows, active-low (master -> slave)
//   col_out   : column drive, active-low one-cold (slave -> master)
//   key_code  : {row[1:0], col[1:0]} of the accepted key (slave -> master)
//   key_valid : one-clk pulse per accepted key event (slave -> master)
//   key_held  : high while the accepted key is debounced-down (slave -> master)
interface keypad_scan_if;
  logic       scan_tick;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    output scan_tick, row_in,
    input  col_out, key_code, key_valid, key_held
  );

  modport slave (
    input  scan_tick, row_in,
    output col_out, key_code, key_valid, key_held
  );
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan -- 4x4 matrix keypad scanner with press/release debounce.
// Ports:
//   clk : single clock, rising edge
//   rst : synchronous active-high reset
//   bus : keypad_scan_if.slave (scan_tick, row_in in; col_out, key_code,
//         key_valid, key_held out; all outputs registered)
// Parameters:
//   DEBOUNCE_CNT : matching scan ticks to accept a press or release (2..15)
//   REPEAT_TICKS : scan ticks between auto-repeat events (2..255)
// Optional feature: define KEYPAD_REPEAT_EN to enable auto-repeat of
// key_valid while a key stays pressed.
module keypad_scan #(
  parameter int unsigned DEBOUNCE_CNT = 4,
  parameter int unsigned REPEAT_TICKS = 32
) (
  input logic         clk,
  input logic         rst,
  keypad_scan_if.slave bus
);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

  // The tick that enters DEBOUNCE/RELEASE is the first qualifying sample,
  // so the counter only has to climb to DEBOUNCE_CNT-1 across the rest.
  localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CNT - 2);

  if (DEBOUNCE_CNT < 2 || DEBOUNCE_CNT > 15 ||
      REPEAT_TICKS < 2 || REPEAT_TICKS > 255) begin : g_bad_cfg
    $error("keypad_scan: DEBOUNCE_CNT or REPEAT_TICKS out of range");
  end

  state_t     r_state, w_state_nxt;
  logic [1:0] r_col, w_col_nxt;
  logic [3:0] r_col_out, w_col_out_nxt;
  logic [3:0] r_pat, w_pat_nxt;
  logic [1:0] r_row, w_row_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_key_code, w_key_code_nxt;
  logic       r_key_valid, w_key_valid_nxt;
  logic       r_key_held, w_key_held_nxt;
`ifdef KEYPAD_REPEAT_EN
  localparam logic [7:0] REP_LAST = 8'(REPEAT_TICKS - 1);
  logic [7:0] r_rep_cnt, w_rep_cnt_nxt;
`endif

  logic       w_idle;
  logic       w_match;
  logic       w_cnt_done;
  logic [1:0] w_row_lo;

  assign w_idle     = (bus.row_in == 4'hF);
  assign w_match    = (bus.row_in == r_pat);
  assign w_cnt_done = (r_cnt == CNT_LAST);

  // Lowest-index closed row wins when several rows read low.
  always_comb begin
    w_row_lo = '0;
    for (int unsigned i = 4; i > 0; i--) begin
      if (!bus.row_in[i-1]) w_row_lo = 2'(i - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_SCAN;
      r_col       <= '0;
      r_col_out   <= 4'b1110;
      r_pat       <= '1;
      r_row       <= '0;
      r_cnt       <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep_cnt   <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_col       <= w_col_nxt;
      r_col_out   <= w_col_out_nxt;
      r_pat       <= w_pat_nxt;
      r_row       <= w_row_nxt;
      r_cnt       <= w_cnt_nxt;
      r_key_code  <= w_key_code_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_key_held  <= w_key_held_nxt;
`ifdef KEYPAD_REPEAT_EN
      r_rep_cnt   <= w_rep_cnt_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.scan_tick) begin
      case (r_state)
        S_SCAN:     if (!w_idle) w_state_nxt = S_DEBOUNCE;
        S_DEBOUNCE: if (!w_match) w_state_nxt = S_SCAN;
                    else if (w_cnt_done) w_state_nxt = S_PRESSED;
        S_PRESSED:  if (w_idle) w_state_nxt = S_RELEASE;
        S_RELEASE:  if (!w_idle) w_state_nxt = S_PRESSED;
                    else if (w_cnt_done) w_state_nxt = S_SCAN;
        default:    w_state_nxt = S_SCAN;
      endcase
    end
  end

  always_comb begin
    w_col_nxt       = r_col;
    w_col_out_nxt   = r_col_out;
    w_pat_nxt       = r_pat;
    w_row_nxt       = r_row;
    w_cnt_nxt       = r_cnt;
    w_key_code_nxt  = r_key_code;
    w_key_valid_nxt = 1'b0;
    w_key_held_nxt  = r_key_held;
`ifdef KEYPAD_REPEAT_EN
    w_rep_cnt_nxt   = r_rep_cnt;
`endif
    if (bus.scan_tick) begin
      // Every tick that lands in SCAN (idle scan, bounce abort, release
      // done) moves on to the next column.
      if (w_state_nxt == S_SCAN) begin
        w_col_nxt     = r_col + 2'd1;
        w_col_out_nxt = ~(4'b0001 << w_col_nxt);
      end
      case (r_state)
        S_SCAN: if (!w_idle) begin
          w_pat_nxt = bus.row_in;
          w_row_nxt = w_row_lo;
          w_cnt_nxt = '0;
        end
        S_DEBOUNCE: if (w_match) begin
          w_cnt_nxt = r_cnt + 4'd1;
          if (w_cnt_done) begin
            w_key_code_nxt  = {r_row, r_col};
            w_key_valid_nxt = 1'b1;
          end
        end
        S_PRESSED: if (w_idle) w_cnt_nxt = '0;
        S_RELEASE: if (w_idle) w_cnt_nxt = r_cnt + 4'd1;
        default: ;
      endcase
      w_key_held_nxt = (w_state_nxt == S_PRESSED) || (w_state_nxt == S_RELEASE);
`ifdef KEYPAD_REPEAT_EN
      // Cleared only on a fresh acceptance; a bounce back from RELEASE
      // resumes the running count.
      if (r_state == S_DEBOUNCE && w_state_nxt == S_PRESSED) begin
        w_rep_cnt_nxt = '0;
      end else if (r_state == S_PRESSED && w_state_nxt == S_PRESSED) begin
        if (r_rep_cnt == REP_LAST) begin
          w_rep_cnt_nxt   = '0;
          w_key_valid_nxt = 1'b1;
        end else begin
          w_rep_cnt_nxt = r_rep_cnt + 8'd1;
        end
      end
`endif
    end
  end

  assign bus.col_out   = r_col_out;
  assign bus.key_code  = r_key_code;
  assign bus.key_valid = r_key_valid;
  assign bus.key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan -- self-checking bench for keypad_scan.
// Expected key events are queued as the qualifying tick is driven and
// popped by a monitor whenever key_valid is seen.
module tb_keypad_scan;
  localparam int unsigned DC = 4;
  localparam int unsigned RT = 32;
`ifdef KEYPAD_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  keypad_scan_if bus ();

  keypad_scan #(.DEBOUNCE_CNT(DC), .REPEAT_TICKS(RT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [3:0]  sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic tk, input logic [3:0] row);
    @(negedge clk);
    bus.scan_tick = tk;
    bus.row_in    = row;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    check("col_onecold", 32'($countones(~bus.col_out)), 1);
    if (bus.key_valid === 1'b1) begin
      if (sb_q.size() == 0) check("unexp_valid", {31'd0, bus.key_valid}, 0);
      else                  check("sb_code", {28'd0, bus.key_code}, {28'd0, sb_q.pop_front()});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_cols [4];
    logic       exp_v;
    exp_cols = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    rst = 1'b1;
    bus.scan_tick = 1'b1;
    bus.row_in    = 4'hF;
    repeat (3) step(1'b1, 4'hF);
    check("rst_col",   bus.col_out, 4'b1110);
    check("rst_code",  bus.key_code, 4'h0);
    check("rst_valid", bus.key_valid, 0);
    check("rst_held",  bus.key_held, 0);
    rst = 1'b0;

    // idle scan rotation
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'hF);
      check("scan_col", bus.col_out, exp_cols[i]);
    end
    step(1'b1, 4'hF);
    check("scan_col1", bus.col_out, 4'b1101);

    // row 2 / col 1 held stable -> code 9
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b1011);
      check("deb_held",  bus.key_held, 0);
      check("deb_valid", bus.key_valid, 0);
      check("deb_col",   bus.col_out, 4'b1101);
    end
    sb_q.push_back(4'h9);
    step(1'b1, 4'b1011);
    check("acc_valid", bus.key_valid, 1);
    check("acc_code",  bus.key_code, 4'h9);
    check("acc_held",  bus.key_held, 1);
    step(1'b0, 4'b1011);
    check("pulse_end", bus.key_valid, 0);
    check("hold_noticks", bus.key_held, 1);
    step(1'b1, 4'b1011);
    check("press_novalid", bus.key_valid, 0);
    step(1'b1, 4'b1001);
    check("second_key_valid", bus.key_valid, 0);
    check("second_key_code",  bus.key_code, 4'h9);

    // release with a glitch
    step(1'b1, 4'hF);
    step(1'b1, 4'hF);
    step(1'b1, 4'b1011);
    check("glitch_held", bus.key_held, 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'hF);
      check("rel_held", bus.key_held, 1);
    end
    step(1'b1, 4'hF);
    check("rel_drop", bus.key_held, 0);
    check("rel_col",  bus.col_out, 4'b1011);

    // bounce at column 1 -> no key, scanning resumes at column 2
    repeat (3) step(1'b1, 4'hF);
    check("pre_bounce_col", bus.col_out, 4'b1101);
    step(1'b1, 4'b1011);
    step(1'b1, 4'hF);
    check("bounce_col", bus.col_out, 4'b1011);
    step(1'b1, 4'b1011);
    check("bounce_held", bus.key_held, 0);
    step(1'b1, 4'hF);
    check("bounce_next_col", bus.col_out, 4'b0111);

    // reset during debounce at column 3
    step(1'b1, 4'b1110);
    step(1'b1, 4'b1110);
    rst = 1'b1;
    step(1'b1, 4'b1110);
    rst = 1'b0;
    check("mid_rst_col",   bus.col_out, 4'b1110);
    check("mid_rst_held",  bus.key_held, 0);
    check("mid_rst_valid", bus.key_valid, 0);
    check("mid_rst_code",  bus.key_code, 4'h0);
    step(1'b1, 4'hF);
    step(1'b1, 4'hF);
    check("post_rst_col", bus.col_out, 4'b1011);

    // row 1 / col 2 -> code 6
    repeat (3) step(1'b1, 4'b1101);
    sb_q.push_back(4'h6);
    step(1'b1, 4'b1101);
    check("k6_valid", bus.key_valid, 1);
    check("k6_code",  bus.key_code, 4'h6);
    repeat (4) step(1'b1, 4'hF);
    check("k6_rel_held", bus.key_held, 0);
    check("k6_rel_col",  bus.col_out, 4'b0111);

    // key 0 held 100 ticks (auto-repeat when enabled)
    step(1'b1, 4'hF);
    check("k0_col", bus.col_out, 4'b1110);
    repeat (3) step(1'b1, 4'b1110);
    sb_q.push_back(4'h0);
    step(1'b1, 4'b1110);
    check("k0_valid", bus.key_valid, 1);
    for (int k = 1; k <= 100; k++) begin
      exp_v = REP_EN && (k % RT == 0);
      if (exp_v) sb_q.push_back(4'h0);
      step(1'b1, 4'b1110);
      check("rep_valid", bus.key_valid, {31'd0, exp_v});
    end
    check("rep_held", bus.key_held, 1);
    repeat (4) step(1'b1, 4'hF);
    check("k0_rel_held", bus.key_held, 0);

    repeat (2) step(1'b0, 4'hF);
    check("sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter DEBOUNCE_CNT, default 4: consecutive scan_tick samples needed to accept a press or a release (legal 2..15).
REQ-002 SHALL have parameter REPEAT_TICKS, default 32: scan_tick count between auto-repeat events (legal 2..255).
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port scan_tick, input, 1: one-clk step strobe; all FSM and counter activity advances only on clk edges where scan_tick=1.
REQ-006 SHALL have port row_in, input, 4: keypad rows, active-low, externally synchronized; bit r=0 means a key in row r is closed on the driven column.
REQ-007 SHALL have port col_out, output, 4: column drive, active-low, one-cold; bit c=0 drives column c.
REQ-008 SHALL have port key_code, output, 4: {row[1:0], col[1:0]} of the accepted key.
REQ-009 SHALL have port key_valid, output, 1: one-clk pulse per accepted key event.
REQ-010 SHALL have port key_held, output, 1: high while the accepted key is debounced-down.

Function
REQ-011 SHALL implement FSM states SCAN, DEBOUNCE, PRESSED, RELEASE; every output is registered.
REQ-012 SCAN: on each scan_tick, if row_in==4'b1111, the column index SHALL advance c -> (c+1) mod 4 (3 wraps to 0) and col_out SHALL become ~(1<<c).
REQ-013 SCAN: on a scan_tick with row_in!=4'b1111, the FSM SHALL hold the column, latch row_in as the pattern, latch the row as the lowest-index 0 bit, clear the counter, and enter DEBOUNCE.
REQ-014 DEBOUNCE: on each scan_tick with row_in equal to the latched pattern, the counter SHALL increment; on the tick where the count reaches DEBOUNCE_CNT-1 the FSM SHALL enter PRESSED.
REQ-015 DEBOUNCE: on a scan_tick with row_in not equal to the pattern, the FSM SHALL return to SCAN and advance the column, with no key_valid.
REQ-016 On entry to PRESSED, key_code SHALL update and key_valid SHALL pulse high for exactly one clk, in the cycle after the qualifying tick edge; key_held SHALL rise in the same cycle.
REQ-017 PRESSED: on a scan_tick with row_in==4'b1111, the FSM SHALL clear the counter and enter RELEASE; any other row_in SHALL keep it in PRESSED (a second key is ignored).
REQ-018 RELEASE: DEBOUNCE_CNT consecutive scan_ticks with row_in==4'b1111 SHALL return the FSM to SCAN, drop key_held and advance the column; any tick with row_in!=4'b1111 SHALL return it to PRESSED with no new key_valid.
REQ-019 key_held SHALL be 1 in PRESSED and RELEASE and 0 otherwise; key_code SHALL hold its last value outside PRESSED entry.
REQ-020 With scan_tick=0, all state, counters and outputs SHALL hold; key_valid SHALL be 0.
REQ-021 col_out SHALL always have exactly one 0 bit.

Reset
REQ-022 When rst=1 at a clk edge, regardless of scan_tick, the block SHALL set state SCAN, column 0, col_out=4'b1110, key_code=4'h0, key_valid=0, key_held=0, and all counters to 0.
REQ-023 Reset asserted mid-debounce or mid-press SHALL discard the event without a key_valid pulse.

Configuration
REQ-024 Macro KEYPAD_REPEAT_EN defined: in PRESSED, a repeat counter SHALL count scan_ticks; every REPEAT_TICKS ticks it SHALL re-pulse key_valid with an unchanged key_code; the counter SHALL clear on entry to PRESSED and hold in RELEASE.
REQ-025 Macro KEYPAD_REPEAT_EN undefined: no repeat logic SHALL be present; exactly one key_valid pulse per press.

Verification
REQ-026 rst held 3 clks, then scan_tick every clk and row_in=4'hF -> col_out sequence 1110,1101,1011,0111,1110; key_valid never 1.
REQ-027 Key row 2/col 1 held stable (row_in=4'b1011 while col_out=4'b1101) -> exactly one key_valid with key_code=4'h9 after 4 matching ticks, and key_held=1.
REQ-028 Same key bouncing (row_in alternating 1011/1111 every tick for 3 ticks) -> no key_valid; scanning resumes at column 2.
REQ-029 Release with a 2-tick glitch (1111,1111,1011, then 1111 x4) -> key_held stays 1 through the glitch and drops after the 4th clean tick; no second key_valid.
REQ-030 KEYPAD_REPEAT_EN defined, key 4'h0 held for 100 ticks after acceptance -> 3 additional key_valid pulses, 32 ticks apart, key_code=4'h0.
REQ-031 rst pulsed 1 clk during DEBOUNCE -> col_out=4'b1110, key_held=0, and no key_valid.
